// File: rtl/pipeline_sched.sv
// pipeline_sched: stall/flush/redirect sequencer for the 5-stage CPU.
// Owns per-stage stall/flush, PC redirect, EPC/cause and interrupt entry/return.
// Optional feature macro: SCHED_EXT_INT_EN adds a level-sensitive external
// interrupt input (sci_ext_int/sci_ext_cause) taken just below software INT.
// Outputs are combinational from the registered state plus the current inputs;
// state, stall counter, epc and cause are registers.
module pipeline_sched #(
  parameter logic [15:0] HANDLER_ADDR = 16'h0008,
  parameter logic [3:0]  ERET_ID      = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sci_mem_pause,
  input  logic        sci_id_pause,
  input  logic [3:0]  sci_id_sched_type,
  input  logic [3:0]  sci_id_sched_count,
  input  logic        sci_branch,
  input  logic [15:0] sci_branch_pc,
  input  logic        sci_int,
  input  logic [3:0]  sci_int_id,
  input  logic [15:0] sci_id_addr,
`ifdef SCHED_EXT_INT_EN
  input  logic        sci_ext_int,
  input  logic [3:0]  sci_ext_cause,
`endif
  output logic [4:0]  sco_stall,
  output logic [4:0]  sco_flush,
  output logic        sco_pc_sel,
  output logic [15:0] sco_new_pc,
  output logic [15:0] sco_epc,
  output logic [7:0]  sco_cause,
  output logic        sco_busy
);

  localparam logic [3:0] SCHED_PAUSE_FOR_LW = 4'd1;
  localparam logic [3:0] SCHED_PAUSE_N      = 4'd2;

  // Stall/flush bit patterns: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB
  localparam logic [4:0] MEM_STALL   = 5'b00001;
  localparam logic [4:0] MEM_FLUSH   = 5'b00010;
  localparam logic [4:0] LD_STALL    = 5'b00011;
  localparam logic [4:0] LD_FLUSH    = 5'b00100;
  localparam logic [4:0] INT_FLUSH   = 5'b00110;
  localparam logic [4:0] JUMP_FLUSH  = 5'b00010;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_INT_SAVE = 2'd2,
    ST_INT_JUMP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] epc_q, epc_d;
  logic [7:0]  cause_q, cause_d;

  logic [4:0]  stall_s;
  logic [4:0]  flush_s;
  logic        pc_sel_s;
  logic [15:0] new_pc_s;
  logic [3:0]  pause_rem_s;

  // PAUSE_N with count 0 behaves as a one-cycle pause; remaining cycles after this one.
  assign pause_rem_s = (sci_id_sched_count == 4'd0) ? 4'd0 : (sci_id_sched_count - 4'd1);

  // Next-state and per-cycle control outputs, one action per cycle by priority.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    stall_s  = 5'b00000;
    flush_s  = 5'b00000;
    pc_sel_s = 1'b0;
    new_pc_s = 16'h0000;
    case (state_q)
      ST_RUN: begin
        if (sci_mem_pause) begin
          // SRAM owned by mem: hold PC, bubble IF/ID, defer everything else.
          stall_s = MEM_STALL;
          flush_s = MEM_FLUSH;
        end else if (sci_int && (sci_int_id != ERET_ID)) begin
          flush_s = INT_FLUSH;
          epc_d   = sci_id_addr + 16'd1;
          cause_d = {4'h0, sci_int_id};
          state_d = ST_INT_SAVE;
        end else if (sci_int) begin
          // ERET: return to the saved PC immediately.
          pc_sel_s = 1'b1;
          new_pc_s = epc_q;
          flush_s  = JUMP_FLUSH;
`ifdef SCHED_EXT_INT_EN
        end else if (sci_ext_int) begin
          // Instruction in id is discarded and re-executed after return.
          flush_s = INT_FLUSH;
          epc_d   = sci_id_addr;
          cause_d = {4'h8, sci_ext_cause};
          state_d = ST_INT_SAVE;
`endif
        end else if (sci_id_pause && (sci_id_sched_type == SCHED_PAUSE_FOR_LW)) begin
          stall_s = LD_STALL;
          flush_s = LD_FLUSH;
        end else if (sci_id_pause && (sci_id_sched_type == SCHED_PAUSE_N)) begin
          stall_s = LD_STALL;
          flush_s = LD_FLUSH;
          cnt_d   = pause_rem_s;
          if (pause_rem_s != 4'd0) begin
            state_d = ST_STALL;
          end else begin
            state_d = ST_RUN;
          end
        end else if (sci_branch) begin
          // Delay slot is kept, so no flush on a taken branch.
          pc_sel_s = 1'b1;
          new_pc_s = sci_branch_pc;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STALL: begin
        if (sci_mem_pause) begin
          // Counter holds so mem pauses extend rather than consume the stall.
          stall_s = MEM_STALL;
          flush_s = MEM_FLUSH;
        end else begin
          stall_s = LD_STALL;
          flush_s = LD_FLUSH;
          cnt_d   = (cnt_q == 4'd0) ? 4'd0 : (cnt_q - 4'd1);
          if (cnt_q <= 4'd1) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_STALL;
          end
        end
      end
      ST_INT_SAVE: begin
        // Drain delay slot and the already-fetched instruction.
        flush_s = INT_FLUSH;
        state_d = ST_INT_JUMP;
      end
      ST_INT_JUMP: begin
        if (sci_mem_pause) begin
          stall_s = MEM_STALL;
          flush_s = MEM_FLUSH;
        end else begin
          pc_sel_s = 1'b1;
          new_pc_s = HANDLER_ADDR;
          flush_s  = JUMP_FLUSH;
          state_d  = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Scheduler state, stall counter, and saved EPC/cause registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      epc_q   <= 16'h0000;
      cause_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  assign sco_stall  = stall_s;
  assign sco_flush  = flush_s;
  assign sco_pc_sel = pc_sel_s;
  assign sco_new_pc = new_pc_s;
  assign sco_epc    = epc_q;
  assign sco_cause  = cause_q;
  assign sco_busy   = (state_q != ST_RUN);

endmodule

// File: tb/tb_pipeline_sched.sv
// Directed testbench for pipeline_sched: hand-computed expectations per step.
module tb_pipeline_sched;

  logic        clk;
  logic        rst;
  logic        sci_mem_pause;
  logic        sci_id_pause;
  logic [3:0]  sci_id_sched_type;
  logic [3:0]  sci_id_sched_count;
  logic        sci_branch;
  logic [15:0] sci_branch_pc;
  logic        sci_int;
  logic [3:0]  sci_int_id;
  logic [15:0] sci_id_addr;
`ifdef SCHED_EXT_INT_EN
  logic        sci_ext_int;
  logic [3:0]  sci_ext_cause;
`endif
  logic [4:0]  sco_stall;
  logic [4:0]  sco_flush;
  logic        sco_pc_sel;
  logic [15:0] sco_new_pc;
  logic [15:0] sco_epc;
  logic [7:0]  sco_cause;
  logic        sco_busy;

  int checks;
  int failures;

  pipeline_sched dut (
    .clk               (clk),
    .rst               (rst),
    .sci_mem_pause     (sci_mem_pause),
    .sci_id_pause      (sci_id_pause),
    .sci_id_sched_type (sci_id_sched_type),
    .sci_id_sched_count(sci_id_sched_count),
    .sci_branch        (sci_branch),
    .sci_branch_pc     (sci_branch_pc),
    .sci_int           (sci_int),
    .sci_int_id        (sci_int_id),
    .sci_id_addr       (sci_id_addr),
`ifdef SCHED_EXT_INT_EN
    .sci_ext_int       (sci_ext_int),
    .sci_ext_cause     (sci_ext_cause),
`endif
    .sco_stall         (sco_stall),
    .sco_flush         (sco_flush),
    .sco_pc_sel        (sco_pc_sel),
    .sco_new_pc        (sco_new_pc),
    .sco_epc           (sco_epc),
    .sco_cause         (sco_cause),
    .sco_busy          (sco_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    sci_mem_pause      = 1'b0;
    sci_id_pause       = 1'b0;
    sci_id_sched_type  = 4'd0;
    sci_id_sched_count = 4'd0;
    sci_branch         = 1'b0;
    sci_branch_pc      = 16'h0000;
    sci_int            = 1'b0;
    sci_int_id         = 4'd0;
    sci_id_addr        = 16'h0000;
`ifdef SCHED_EXT_INT_EN
    sci_ext_int        = 1'b0;
    sci_ext_cause      = 4'd0;
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clear_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_stall", {11'd0, sco_stall}, 16'h0000);
    chk("rst_flush", {11'd0, sco_flush}, 16'h0000);
    chk("rst_pcsel", {15'd0, sco_pc_sel}, 16'h0000);
    chk("rst_epc", sco_epc, 16'h0000);
    chk("rst_cause", {8'd0, sco_cause}, 16'h0000);
    chk("rst_busy", {15'd0, sco_busy}, 16'h0000);

    // PAUSE_FOR_LW: one cycle only
    sci_id_pause = 1'b1; sci_id_sched_type = 4'd1; #1;
    chk("lw_stall", {11'd0, sco_stall}, 16'h0003);
    chk("lw_flush", {11'd0, sco_flush}, 16'h0004);
    tick(); clear_in(); #1;
    chk("lw_after_stall", {11'd0, sco_stall}, 16'h0000);
    chk("lw_after_busy", {15'd0, sco_busy}, 16'h0000);

    // PAUSE_N with count 0 acts as count 1
    sci_id_pause = 1'b1; sci_id_sched_type = 4'd2; sci_id_sched_count = 4'd0; #1;
    chk("n0_stall", {11'd0, sco_stall}, 16'h0003);
    tick(); clear_in(); #1;
    chk("n0_after_busy", {15'd0, sco_busy}, 16'h0000);
    chk("n0_after_stall", {11'd0, sco_stall}, 16'h0000);

    // PAUSE_N count 3 with mem_pause in the 2nd cycle
    sci_id_pause = 1'b1; sci_id_sched_type = 4'd2; sci_id_sched_count = 4'd3; #1;
    chk("n3_c1_stall", {11'd0, sco_stall}, 16'h0003);
    chk("n3_c1_flush", {11'd0, sco_flush}, 16'h0004);
    tick(); clear_in(); sci_mem_pause = 1'b1; #1;
    chk("n3_c2_stall", {11'd0, sco_stall}, 16'h0001);
    chk("n3_c2_flush", {11'd0, sco_flush}, 16'h0002);
    chk("n3_c2_busy", {15'd0, sco_busy}, 16'h0001);
    tick(); sci_mem_pause = 1'b0; #1;
    chk("n3_c3_stall", {11'd0, sco_stall}, 16'h0003);
    tick(); #1;
    chk("n3_c4_stall", {11'd0, sco_stall}, 16'h0003);
    chk("n3_c4_busy", {15'd0, sco_busy}, 16'h0001);
    tick(); #1;
    chk("n3_c5_stall", {11'd0, sco_stall}, 16'h0000);
    chk("n3_c5_busy", {15'd0, sco_busy}, 16'h0000);

    // Software INT id=3 at 0x0040
    sci_int = 1'b1; sci_int_id = 4'd3; sci_id_addr = 16'h0040; #1;
    chk("int_flush", {11'd0, sco_flush}, 16'h0006);
    chk("int_pcsel", {15'd0, sco_pc_sel}, 16'h0000);
    tick(); clear_in(); #1;
    chk("int_epc", sco_epc, 16'h0041);
    chk("int_cause", {8'd0, sco_cause}, 16'h0003);
    chk("save_busy", {15'd0, sco_busy}, 16'h0001);
    chk("save_flush", {11'd0, sco_flush}, 16'h0006);
    chk("save_pcsel", {15'd0, sco_pc_sel}, 16'h0000);
    tick(); #1;
    chk("jump_busy", {15'd0, sco_busy}, 16'h0001);
    chk("jump_pcsel", {15'd0, sco_pc_sel}, 16'h0001);
    chk("jump_newpc", sco_new_pc, 16'h0008);
    chk("jump_flush", {11'd0, sco_flush}, 16'h0002);
    tick(); #1;
    chk("int_done_busy", {15'd0, sco_busy}, 16'h0000);

    // ERET returns to epc in the same cycle
    sci_int = 1'b1; sci_int_id = 4'hF; #1;
    chk("eret_pcsel", {15'd0, sco_pc_sel}, 16'h0001);
    chk("eret_newpc", sco_new_pc, 16'h0041);
    chk("eret_flush", {11'd0, sco_flush}, 16'h0002);
    tick(); clear_in(); #1;
    chk("eret_busy", {15'd0, sco_busy}, 16'h0000);

    // EPC wrap at 0xFFFF
    sci_int = 1'b1; sci_int_id = 4'd1; sci_id_addr = 16'hFFFF; #1;
    tick(); clear_in(); #1;
    chk("wrap_epc", sco_epc, 16'h0000);
    chk("wrap_cause", {8'd0, sco_cause}, 16'h0001);
    tick(); tick(); #1;

    // mem_pause holds INT_JUMP
    sci_int = 1'b1; sci_int_id = 4'd5; sci_id_addr = 16'h0040; #1;
    tick(); clear_in(); tick(); sci_mem_pause = 1'b1; #1;
    chk("jmp_mp_pcsel", {15'd0, sco_pc_sel}, 16'h0000);
    chk("jmp_mp_stall", {11'd0, sco_stall}, 16'h0001);
    tick(); sci_mem_pause = 1'b0; #1;
    chk("jmp_mp_busy", {15'd0, sco_busy}, 16'h0001);
    chk("jmp_mp_newpc", sco_new_pc, 16'h0008);
    tick(); #1;

    // Branch deferred by mem_pause
    sci_mem_pause = 1'b1; sci_branch = 1'b1; sci_branch_pc = 16'h0100; #1;
    chk("br_mp_pcsel", {15'd0, sco_pc_sel}, 16'h0000);
    chk("br_mp_stall", {11'd0, sco_stall}, 16'h0001);
    tick(); sci_mem_pause = 1'b0; #1;
    chk("br_pcsel", {15'd0, sco_pc_sel}, 16'h0001);
    chk("br_newpc", sco_new_pc, 16'h0100);
    chk("br_flush", {11'd0, sco_flush}, 16'h0000);
    tick(); clear_in(); #1;

    // Load-use pause outranks branch
    sci_id_pause = 1'b1; sci_id_sched_type = 4'd1; sci_branch = 1'b1; sci_branch_pc = 16'h0200; #1;
    chk("lw_br_pcsel", {15'd0, sco_pc_sel}, 16'h0000);
    tick(); clear_in(); #1;

    // Reset held 2 cycles mid-STALL
    sci_id_pause = 1'b1; sci_id_sched_type = 4'd2; sci_id_sched_count = 4'd5; #1;
    tick(); clear_in(); tick(); #1;
    chk("pre_rst_busy", {15'd0, sco_busy}, 16'h0001);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; #1;
    chk("mid_rst_busy", {15'd0, sco_busy}, 16'h0000);
    chk("mid_rst_stall", {11'd0, sco_stall}, 16'h0000);
    chk("mid_rst_flush", {11'd0, sco_flush}, 16'h0000);
    chk("mid_rst_epc", sco_epc, 16'h0000);
    chk("mid_rst_cause", {8'd0, sco_cause}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
